// File: rtl/counter_watermark_monitor_if.sv
// Request bus shared by the credit counter and its watermark monitor.
// The counter side drives it; the monitor only observes it.
interface counter_watermark_monitor_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] value;
    logic             reinit;
    logic             incr_valid;
    logic [1:0]       incr;
    logic             decr_valid;
    logic [1:0]       decr;

    modport master (
        output value, reinit, incr_valid, incr, decr_valid, decr
    );

    modport slave (
        input value, reinit, incr_valid, incr, decr_valid, decr
    );
endinterface

// File: rtl/counter_watermark_monitor.sv
// Debounced high/low watermark tracker with hysteresis, peak capture
// and sticky range-violation flags for a credit/occupancy counter.
module counter_watermark_monitor #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    counter_watermark_monitor_if.slave  bus,
    input  logic [WIDTH-1:0]            hi_mark,
    input  logic [WIDTH-1:0]            lo_mark,
    input  logic                        clear,
    output logic [1:0]                  state,
    output logic                        hi_event,
    output logic                        lo_event,
    output logic [WIDTH-1:0]            peak,
    output logic                        ovf_err,
    output logic                        udf_err
);

    localparam logic [1:0] MID  = 2'b00;
    localparam logic [1:0] HIGH = 2'b01;
    localparam logic [1:0] LOW  = 2'b10;

    localparam logic [2:0] HOLD3 = 3'(HOLD);

    logic             hc;
    logic             lc;
    logic [2:0]       dbnc;
    logic [2:0]       dbnc_nx;
    logic [2:0]       cnt;
    logic             cand;
    logic             cand_nx;
    logic [1:0]       state_nx;
    logic [WIDTH+1:0] e;
    logic             ovf_now;
    logic             udf_now;

    assign hc = bus.value >= hi_mark;
    assign lc = bus.value <= lo_mark;

    // Projected counter result; two spare bits hold sign and carry.
    assign e = {2'b00, bus.value}
             + {{WIDTH{1'b0}}, (bus.incr_valid ? bus.incr : 2'b00)}
             - {{WIDTH{1'b0}}, (bus.decr_valid ? bus.decr : 2'b00)};

    assign ovf_now = !bus.reinit && !e[WIDTH+1] && e[WIDTH];
    assign udf_now = !bus.reinit && e[WIDTH+1];

    // Debounce: count consecutive qualifying edges, move when HOLD reached.
    always_comb begin
        state_nx = state;
        dbnc_nx  = 3'd0;
        cand_nx  = cand;
        cnt      = 3'd0;
        case (state)
            MID: begin
                if (hc || lc) begin
                    cnt     = (dbnc != 3'd0 && cand == hc) ? dbnc + 3'd1 : 3'd1;
                    cand_nx = hc;
                    if (cnt == HOLD3) state_nx = hc ? HIGH : LOW;
                    else              dbnc_nx  = cnt;
                end
            end
            HIGH: begin
                if (!hc) begin
                    cnt = dbnc + 3'd1;
                    if (cnt == HOLD3) state_nx = MID;
                    else              dbnc_nx  = cnt;
                end
            end
            LOW: begin
                if (!lc) begin
                    cnt = dbnc + 3'd1;
                    if (cnt == HOLD3) state_nx = MID;
                    else              dbnc_nx  = cnt;
                end
            end
            default: state_nx = MID;
        endcase
    end

    // Watermark state, debounce count and entry events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MID;
            dbnc     <= 3'd0;
            cand     <= 1'b0;
            hi_event <= 1'b0;
            lo_event <= 1'b0;
        end else begin
            state    <= state_nx;
            dbnc     <= dbnc_nx;
            cand     <= cand_nx;
            hi_event <= (state_nx == HIGH) && (state != HIGH);
            lo_event <= (state_nx == LOW) && (state != LOW);
        end
    end

    // Peak and sticky range flags; a same-edge violation beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak    <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (clear) begin
            peak    <= bus.value;
            ovf_err <= ovf_now;
            udf_err <= udf_now;
        end else begin
            peak    <= (bus.value > peak) ? bus.value : peak;
            ovf_err <= ovf_err | ovf_now;
            udf_err <= udf_err | udf_now;
        end
    end

endmodule

// File: tb/tb_counter_watermark_monitor.sv
// Directed-vector bench for counter_watermark_monitor (WIDTH=4, HOLD=2).
// Table rows give the inputs for one edge and the outputs after it.
module tb_counter_watermark_monitor;

    typedef struct {
        logic [3:0] v;
        logic       ri;
        logic       iv;
        logic [1:0] inc;
        logic       dv;
        logic [1:0] dec;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       clr;
        logic [1:0] st;
        logic       he;
        logic       le;
        logic [3:0] pk;
        logic       o;
        logic       u;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] hi_mark;
    logic [3:0] lo_mark;
    logic       clear;
    logic [1:0] state;
    logic       hi_event;
    logic       lo_event;
    logic [3:0] peak;
    logic       ovf_err;
    logic       udf_err;

    int checks;
    int errors;
    vec_t tbl[$];

    counter_watermark_monitor_if #(.WIDTH(4)) bus ();

    counter_watermark_monitor #(.WIDTH(4), .HOLD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hi_mark  (hi_mark),
        .lo_mark  (lo_mark),
        .clear    (clear),
        .state    (state),
        .hi_event (hi_event),
        .lo_event (lo_event),
        .peak     (peak),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int he,
                           input int le, input int pk, input int o,
                           input int u);
        chk({tag, " state"}, int'(state), st);
        chk({tag, " hi_event"}, int'(hi_event), he);
        chk({tag, " lo_event"}, int'(lo_event), le);
        chk({tag, " peak"}, int'(peak), pk);
        chk({tag, " ovf_err"}, int'(ovf_err), o);
        chk({tag, " udf_err"}, int'(udf_err), u);
    endtask

    function automatic void add(input int v, input int ri, input int iv,
                                input int inc, input int dv, input int dec,
                                input int lo, input int clr, input int st,
                                input int he, input int le, input int pk,
                                input int o, input int u);
        vec_t t;
        t.v   = 4'(v);
        t.ri  = 1'(ri);
        t.iv  = 1'(iv);
        t.inc = 2'(inc);
        t.dv  = 1'(dv);
        t.dec = 2'(dec);
        t.hi  = 4'd12;
        t.lo  = 4'(lo);
        t.clr = 1'(clr);
        t.st  = 2'(st);
        t.he  = 1'(he);
        t.le  = 1'(le);
        t.pk  = 4'(pk);
        t.o   = 1'(o);
        t.u   = 1'(u);
        tbl.push_back(t);
    endfunction

    task automatic drive(input logic [3:0] v, input logic ri,
                         input logic iv, input logic [1:0] inc,
                         input logic dv, input logic [1:0] dec,
                         input logic [3:0] hi, input logic [3:0] lo,
                         input logic clr);
        bus.value      = v;
        bus.reinit     = ri;
        bus.incr_valid = iv;
        bus.incr       = inc;
        bus.decr_valid = dv;
        bus.decr       = dec;
        hi_mark        = hi;
        lo_mark        = lo;
        clear          = clr;
    endtask

    task automatic step_plain(input logic [3:0] v);
        @(negedge clk);
        drive(v, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'd12, 4'd3, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //    v  ri iv inc dv dec lo clr st he le pk o u
        add(11, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 11, 0, 0);
        add(12, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 12, 0, 0);
        add(12, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0, 12, 0, 0);
        add(12, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 12, 0, 0);
        add(11, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 12, 0, 0);
        add(12, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 12, 0, 0);
        add(11, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 12, 0, 0);
        add(11, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 12, 0, 0);
        add( 2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 12, 0, 0);
        add( 2, 0, 0, 0, 0, 0, 3, 0, 2, 0, 1, 12, 0, 0);
        add( 2, 0, 0, 0, 0, 0, 3, 0, 2, 0, 0, 12, 0, 0);
        add( 2, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 12, 0, 0);
        add( 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 12, 0, 0);
        add( 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 12, 0, 0);
        add(14, 1, 1, 3, 0, 0, 3, 0, 0, 0, 0, 14, 0, 0);
        add(14, 0, 1, 3, 0, 0, 3, 0, 1, 1, 0, 14, 1, 0);
        add(14, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 14, 1, 0);
        add( 5, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0,  5, 0, 0);
        add( 1, 0, 1, 0, 1, 2, 3, 0, 0, 0, 0,  5, 0, 1);
        add( 1, 0, 1, 0, 1, 2, 3, 1, 0, 0, 0,  1, 0, 1);
        add( 1, 0, 0, 0, 0, 0, 3, 0, 2, 0, 1,  1, 0, 1);
        add(15, 0, 1, 0, 0, 0, 3, 0, 2, 0, 0, 15, 0, 1);
        add( 0, 0, 0, 0, 1, 0, 3, 0, 2, 0, 0, 15, 0, 1);
        add(15, 0, 0, 3, 0, 0, 3, 0, 2, 0, 0, 15, 0, 1);

        rst = 1'b0;
        drive(4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'd12, 4'd3, 1'b0);
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].ri, tbl[i].iv, tbl[i].inc, tbl[i].dv,
                  tbl[i].dec, tbl[i].hi, tbl[i].lo, tbl[i].clr);
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), int'(tbl[i].st), int'(tbl[i].he),
                    int'(tbl[i].le), int'(tbl[i].pk), int'(tbl[i].o),
                    int'(tbl[i].u));
        end

        step_plain(4'd13);
        chk_all("low_exit", 0, 0, 0, 15, 0, 1);
        step_plain(4'd13);
        chk_all("hi_cnt1", 0, 0, 0, 15, 0, 1);
        step_plain(4'd13);
        chk_all("hi_enter", 1, 1, 0, 15, 0, 1);
        step_plain(4'd5);
        chk_all("hi_dbnc", 1, 0, 0, 15, 0, 1);

        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        step_plain(4'd13);
        chk_all("post_rst1", 0, 0, 0, 13, 0, 0);
        step_plain(4'd13);
        chk_all("post_rst2", 1, 1, 0, 13, 0, 0);
        step_plain(4'd13);
        chk_all("post_rst3", 1, 0, 0, 13, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_watermark_monitor.md
# counter_watermark_monitor

Downstream consumer of the credit/occupancy counter. Samples the counter's registered `value` and the same increment/decrement request bus the counter receives. Produces debounced high/low watermark state with hysteresis, one-cycle transition events, a running peak, and sticky overflow/underflow flags for arithmetic that would leave the counter's range. Sits beside the counter in the flow-control path and feeds throttling and interrupt logic.

## Interface
- `WIDTH`, 4: counter width; must match the monitored counter.
- `HOLD`, 2: consecutive sampling edges a condition must hold before a state change; legal range 1..7.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset; asserting low immediately forces all state to reset values.
- `value`  input  WIDTH  registered counter value.
- `reinit`  input  1  counter reinit strobe.
- `incr_valid`  input  1  increment request valid.
- `incr`  input  2  increment amount.
- `decr_valid`  input  1  decrement request valid.
- `decr`  input  2  decrement amount.
- `hi_mark`  input  WIDTH  high watermark, live configuration.
- `lo_mark`  input  WIDTH  low watermark, live configuration.
- `clear`  input  1  synchronous clear of sticky flags and peak.
- `state`  output  2  00 MID, 01 HIGH, 10 LOW; 11 never driven.
- `hi_event`  output  1  one-cycle pulse on entry to HIGH.
- `lo_event`  output  1  one-cycle pulse on entry to LOW.
- `peak`  output  WIDTH  maximum `value` sampled since reset or clear.
- `ovf_err`  output  1  sticky; a request set would exceed 2^WIDTH-1.
- `udf_err`  output  1  sticky; a request set would go below 0.

## Operation
- Conditions are evaluated on the current `value`: `hc` = value >= hi_mark; `lc` = value <= lo_mark. All comparisons are unsigned.
- Debounce counter `dbnc` is 3 bits.
- It counts consecutive edges on which the exit or entry condition for the current state holds.
- It resets to 0 on any edge where that condition is false, and on any state change.
- Transitions, taken on the edge where `dbnc`+1 == HOLD and the condition holds:
  - MID -> HIGH on `hc`. `hc` has priority over `lc` when both hold, which covers lo_mark >= hi_mark misconfiguration.
  - MID -> LOW on `lc`.
  - HIGH -> MID on !`hc`.
  - LOW -> MID on !`lc`.
  - There is no direct HIGH<->LOW transition; the path always goes through MID.
- In MID, `dbnc` tracks whichever candidate (`hc`, else `lc`) holds this edge. It resets if the candidate differs from the previous edge.
- Events:
  - `hi_event` is asserted for exactly the cycle following entry to HIGH.
  - `lo_event` is asserted for exactly the cycle following entry to LOW.
  - Exits to MID produce no event.
- Peak: `peak` <= max(peak, value) every edge.
- Range check on every edge with !`reinit`:
  - Compute `e` = value + (incr_valid ? incr : 0) - (decr_valid ? decr : 0) in signed WIDTH+2 arithmetic.
  - If `e` > 2^WIDTH-1, set `ovf_err`.
  - If `e` < 0, set `udf_err`.
  - Flags stay set until `clear` or reset.
  - Edges with `reinit`=1 perform no check.
- `clear`:
  - `ovf_err` <= 0, `udf_err` <= 0, `peak` <= value.
  - If a violation occurs on the same edge as `clear`, the flag is set; set wins.
  - `state`, `dbnc`, and events are unaffected by `clear`.
- Changing `hi_mark` or `lo_mark` mid-count takes effect on the next edge. A condition that stops holding resets `dbnc`.

## Timing
- Reset values (while `rst` low): `state`=MID, `dbnc`=0, `hi_event`=0, `lo_event`=0, `peak`=0, `ovf_err`=0, `udf_err`=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency:
  - A condition first true at sampling edge t changes `state` after edge t+HOLD-1.
  - The event pulse is high during the cycle after edge t+HOLD-1.
  - HOLD=1 gives a state change on the first qualifying edge.
- Error flags and `peak` update one edge after the offending or peak input.
- Reset deassertion mid-debounce restarts counting from 0. The first qualifying edge after release counts as 1.

## Test plan
- WIDTH=4, HOLD=2, hi=12, lo=3; value goes 11,12,12 -> `state` becomes HIGH after the second 12-edge; `hi_event` is high for one cycle; `peak`=12.
- From HIGH, value goes 11,12,11,11 -> still HIGH after 11,12,11; MID after the fourth edge; no event.
- Value held at 2 for 3 edges from MID -> LOW after edge 2, `lo_event` pulse. Then lo=1 written live -> MID after 2 edges.
- value=14, incr_valid=1, incr=3 -> `ovf_err`=1 next cycle, held. The same stimulus with `reinit`=1 -> no flag. `clear` -> flags 0 and `peak`=value.
- value=1, decr_valid=1, decr=2, incr_valid=1, incr=0 -> `udf_err`=1. With `clear` on the same edge -> `udf_err` stays 1.
- `rst` driven low asynchronously mid-debounce while in HIGH -> `state`=MID and all outputs 0 immediately. After release, value=13 twice -> HIGH.
